// File: rtl/win_pkg.sv
// Shared types and constants for the sequential win scanner.
package win_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;

    typedef enum logic [1:0] {
        DIR_E  = 2'd0,
        DIR_S  = 2'd1,
        DIR_SE = 2'd2,
        DIR_SW = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } scan_state_e;

    function automatic logic is_valid_player(input logic [1:0] id);
        return (id == CELL_P1) || (id == CELL_P2);
    endfunction

endpackage

// File: rtl/win_scanner_if.sv
// Request/result bundle between the game logic and the win scanner.
interface win_scanner_if #(
    parameter int unsigned N = 5
);
    logic                    start;
    logic [2*N*N-1:0]        board;
    logic [1:0]              player_id;
    logic                    busy;
    logic                    done;
    logic                    won;
    logic                    bad_id;
    logic [$clog2(N)-1:0]    win_row;
    logic [$clog2(N)-1:0]    win_col;
    logic [1:0]              win_dir;

    modport master (
        output start, board, player_id,
        input  busy, done, won, bad_id, win_row, win_col, win_dir
    );

    modport slave (
        input  start, board, player_id,
        output busy, done, won, bad_id, win_row, win_col, win_dir
    );
endinterface

// File: rtl/win_window_match.sv
// Combinational check of one K-long window anchored at (row, col) in a given direction.
module win_window_match
    import win_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned K = 4
) (
    input  logic [2*N*N-1:0]     board_i,
    input  logic [$clog2(N)-1:0] row_i,
    input  logic [$clog2(N)-1:0] col_i,
    input  dir_e                 dir_i,
    input  logic [1:0]           player_i,
    output logic                 match_o
);
    int dr;
    int dc;
    int rr;
    int cc;
    int idx;

    always_comb begin
        dr      = 0;
        dc      = 0;
        rr      = 0;
        cc      = 0;
        idx     = 0;
        match_o = 1'b1;
        unique case (dir_i)
            DIR_E:  dc = 1;
            DIR_S:  dr = 1;
            DIR_SE: begin dr = 1; dc = 1;  end
            DIR_SW: begin dr = 1; dc = -1; end
        endcase
        for (int k = 0; k < int'(K); k++) begin
            rr = int'(row_i) + k * dr;
            cc = int'(col_i) + k * dc;
            // Any cell off the board kills the window; no wrap between rows.
            if (rr < 0 || rr >= int'(N) || cc < 0 || cc >= int'(N)) begin
                match_o = 1'b0;
            end else begin
                idx = (rr * int'(N) + cc) * 2;
                if (board_i[idx +: 2] != player_i) match_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/win_scanner.sv
// Sequential win detector: snapshots a board, scans one (cell, dir) window per clock,
// and reports the first matching line.
module win_scanner
    import win_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned K = 4
) (
    input logic          clk,
    input logic          rst,
    win_scanner_if.slave bus
);
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned BW = 2 * N * N;
    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

    scan_state_e   state_q, state_d;
    logic [BW-1:0] snap_q, snap_d;
    logic [1:0]    pid_q, pid_d;
    logic [RW-1:0] r_q, r_d, c_q, c_d;
    dir_e          dir_q, dir_d;
    logic          won_q, won_d;
    logic          bad_q, bad_d;
    logic [RW-1:0] wrow_q, wrow_d, wcol_q, wcol_d;
    dir_e          wdir_q, wdir_d;
    logic          match;
    logic          last_win;

    win_window_match #(
        .N(N),
        .K(K)
    ) u_match (
        .board_i (snap_q),
        .row_i   (r_q),
        .col_i   (c_q),
        .dir_i   (dir_q),
        .player_i(pid_q),
        .match_o (match)
    );

    assign last_win = (r_q == LAST_IDX) && (c_q == LAST_IDX) && (dir_q == DIR_SW);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        pid_d   = pid_q;
        r_d     = r_q;
        c_d     = c_q;
        dir_d   = dir_q;
        won_d   = won_q;
        bad_d   = bad_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wdir_d  = wdir_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    snap_d = bus.board;
                    pid_d  = bus.player_id;
                    r_d    = '0;
                    c_d    = '0;
                    dir_d  = DIR_E;
                    won_d  = 1'b0;
                    wrow_d = '0;
                    wcol_d = '0;
                    wdir_d = DIR_E;
                    if (is_valid_player(bus.player_id)) begin
                        bad_d   = 1'b0;
                        state_d = StScan;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StScan: begin
                if (match) begin
                    won_d   = 1'b1;
                    wrow_d  = r_q;
                    wcol_d  = c_q;
                    wdir_d  = dir_q;
                    state_d = StDone;
                end else if (last_win) begin
                    state_d = StDone;
                end else if (dir_q != DIR_SW) begin
                    dir_d = dir_e'(dir_q + 2'd1);
                end else begin
                    // Direction is innermost, then column, then row.
                    dir_d = DIR_E;
                    if (c_q == LAST_IDX) begin
                        c_d = '0;
                        r_d = r_q + RW'(1);
                    end else begin
                        c_d = c_q + RW'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            snap_q  <= '0;
            pid_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            dir_q   <= DIR_E;
            won_q   <= 1'b0;
            bad_q   <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wdir_q  <= DIR_E;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            pid_q   <= pid_d;
            r_q     <= r_d;
            c_q     <= c_d;
            dir_q   <= dir_d;
            won_q   <= won_d;
            bad_q   <= bad_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wdir_q  <= wdir_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.won     = won_q;
    assign bus.bad_id  = bad_q;
    assign bus.win_row = wrow_q;
    assign bus.win_col = wcol_q;
    assign bus.win_dir = wdir_q;

endmodule

// File: tb/tb_win_scanner.sv
// Scoreboard bench for win_scanner: stimulus pushes expected results, a monitor checks done pulses.
module tb_win_scanner;
    localparam int N  = 5;
    localparam int K  = 4;
    localparam int BW = 2 * N * N;
    localparam int NW = 4 * N * N;

    typedef struct {
        bit won;
        bit bad;
        int row;
        int col;
        int dir;
        int lat;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;
    logic [BW-1:0] bd;

    win_scanner_if #(.N(N)) bus ();

    win_scanner #(
        .N(N),
        .K(K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk window indices in scan order with direction vectors on a 2-D grid.
    function automatic exp_t model(input logic [BW-1:0] b, input logic [1:0] pid);
        exp_t e;
        int   g[N][N];
        int   dr[4] = '{0, 1, 1, 1};
        int   dc[4] = '{1, 0, 1, -1};
        e.won = 0; e.bad = 0; e.row = 0; e.col = 0; e.dir = 0; e.cyc = 0;
        if (pid == 2'd0 || pid == 2'd3) begin
            e.bad = 1;
            e.lat = 1;
            return e;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                g[r][c] = int'(b[(r * N + c) * 2 +: 2]);
        for (int i = 0; i < NW; i++) begin
            int r = i / (4 * N);
            int c = (i / 4) % N;
            int d = i % 4;
            bit hit = 1;
            for (int k = 0; k < K; k++) begin
                int rr = r + k * dr[d];
                int cc = c + k * dc[d];
                if (rr < 0 || rr >= N || cc < 0 || cc >= N) hit = 0;
                else if (g[rr][cc] != int'(pid)) hit = 0;
            end
            if (hit) begin
                e.won = 1; e.row = r; e.col = c; e.dir = d; e.lat = i + 2;
                return e;
            end
        end
        e.lat = 1 + NW;
        return e;
    endfunction

    task automatic set_cell(input int r, input int c, input logic [1:0] v);
        bd[(r * N + c) * 2 +: 2] = v;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no scan pending (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("won", int'(bus.won), int'(mon_e.won));
                check("bad_id", int'(bus.bad_id), int'(mon_e.bad));
                check("win_row", int'(bus.win_row), mon_e.row);
                check("win_col", int'(bus.win_col), mon_e.col);
                check("win_dir", int'(bus.win_dir), mon_e.dir);
            end
        end
    end

    task automatic run_scan(input logic [BW-1:0] b, input logic [1:0] pid, input bit disturb);
        exp_t e;
        bit   busy_ok;
        bit   got;
        @(posedge clk); #1;
        bus.board     = b;
        bus.player_id = pid;
        bus.start     = 1'b1;
        e     = model(b, pid);
        e.cyc = cyc + e.lat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (disturb) begin
            bus.board     = ~b;
            bus.player_id = (pid == 2'd1) ? 2'd2 : 2'd1;
        end
        busy_ok = 1;
        got     = 0;
        for (int n = 0; n < NW + 20 && !got; n++) begin
            @(negedge clk);
            if (!bus.busy) busy_ok = 0;
            if (bus.done) got = 1;
            if (disturb && n == 5) bus.start = 1'b1;
            if (disturb && n == 7) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("busy_during_scan", int'(busy_ok), 1);
        check("done_seen", int'(got), 1);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);
        check("busy_after_done", int'(bus.busy), 0);
        check("won_held", int'(bus.won), int'(e.won));
    endtask

    initial begin
        int c0;
        tests  = 0;
        errors = 0;
        rst    = 1'b1;
        bus.start     = 1'b0;
        bus.board     = '0;
        bus.player_id = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_won", int'(bus.won), 0);
        check("rst_bad_id", int'(bus.bad_id), 0);
        check("rst_win_pos", int'({bus.win_row, bus.win_col, bus.win_dir}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        bd = '0;
        run_scan(bd, 2'd1, 0);

        bd = '0;
        for (int c = 1; c <= 4; c++) set_cell(2, c, 2'd1);
        run_scan(bd, 2'd1, 0);

        bd = '0;
        set_cell(0, 4, 2'd2); set_cell(1, 3, 2'd2); set_cell(2, 2, 2'd2); set_cell(3, 1, 2'd2);
        run_scan(bd, 2'd2, 0);
        run_scan(bd, 2'd1, 0);

        bd = '0;
        set_cell(0, 3, 2'd1); set_cell(0, 4, 2'd1); set_cell(1, 0, 2'd1); set_cell(1, 1, 2'd1);
        run_scan(bd, 2'd1, 0);
        run_scan(bd, 2'd3, 0);
        run_scan(bd, 2'd0, 0);

        // Input changes and a stray start mid-scan must not disturb the snapshot.
        bd = '0;
        for (int c = 1; c <= 4; c++) set_cell(2, c, 2'd1);
        run_scan(bd, 2'd1, 1);

        bd = '0;
        @(posedge clk); #1;
        bus.board     = bd;
        bus.player_id = 2'd1;
        bus.start     = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc < c0 + 10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_won", int'(bus.won), 0);
        repeat (NW + 10) @(negedge clk);

        bd = '0;
        for (int r = 1; r <= 4; r++) set_cell(r, 3, 2'd2);
        run_scan(bd, 2'd2, 0);

        for (int t = 0; t < 24; t++) begin
            logic [1:0] pid;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    set_cell(r, c, 2'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                int ar = $urandom_range(0, N - 1);
                int ac = $urandom_range(0, N - 1);
                int d  = $urandom_range(0, 3);
                int dr = (d == 0) ? 0 : 1;
                int dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                logic [1:0] v = 2'($urandom_range(1, 2));
                for (int k = 0; k < K; k++) begin
                    int rr = ar + k * dr;
                    int cc = ac + k * dc;
                    if (rr >= 0 && rr < N && cc >= 0 && cc < N) set_cell(rr, cc, v);
                end
            end
            case ($urandom_range(0, 9))
                0:       pid = 2'd0;
                1:       pid = 2'd3;
                2, 3, 4: pid = 2'd2;
                default: pid = 2'd1;
            endcase
            run_scan(bd, pid, 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/win_scanner.md
# win_scanner

Parametrised, sequential win detector for the N×N board game datapath. On a `start` pulse it snapshots the board and a player ID. It then scans every (cell, direction) window of length K, one window per clock, and reports the first winning line with its anchor cell and direction. It sits between the move-commit logic and the game FSM, and generalises the combinational 5×5 checker to any board size and run length. It also adds a handshake, early exit and line location.

## Interface
- `N`, default 5: board side length; legal range is 2 or more.
- `K`, default 4: required run length; legal range is 2 ≤ K ≤ N.
- `clk`  in  1: sole clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a scan; accepted only in IDLE.
- `board`  in  2·N·N: flattened board. Cell (r,c) is at `board[(r*N+c)*2 +: 2]`. Codes: 0 = empty, 1 = P1, 2 = P2, 3 = unused.
- `player_id`  in  2: player to test; valid values are 1 and 2.
- `busy`  out  1: high in SCAN and DONE.
- `done`  out  1: one-cycle pulse when a result is valid.
- `won`  out  1: the tested player owns a full K-window.
- `bad_id`  out  1: `player_id` was not 1 or 2 at accept.
- `win_row`, `win_col`  out  $clog2(N) each: anchor cell of the winning window.
- `win_dir`  out  2: 0 = E (0,+1), 1 = S (+1,0), 2 = SE (+1,+1), 3 = SW (+1,−1).

## Operation
- States are IDLE, SCAN and DONE. Reset forces IDLE, and forces `busy`, `done`, `won`, `bad_id`, `win_row`, `win_col` and `win_dir` to 0.
- **Accept:** `start`=1 in IDLE latches `board` and `player_id` into internal registers. It also clears `won`, `bad_id`, `win_*` and the scan index.
  - Later input changes do not affect the scan.
  - `start` is ignored while `busy` is high.
- **Invalid player:** if the latched ID is 0 or 3, go IDLE→DONE directly with `bad_id`=1 and `won`=0.
- **Scan order:** the window index i runs from 0 to 4·N·N−1.
  - Cells are visited row-major with r as the outer loop and c as the inner loop.
  - The direction is innermost, in the order E, S, SE, SW.
  - This gives i = (r·N+c)·4 + dir.
- **Window match:** a window matches only if all K cells lie on the board and each cell equals the latched player ID.
  - A window with any out-of-bounds cell never matches.
  - There is no wrap across rows or columns.
- **Early exit:** the first match moves the FSM SCAN→DONE. It sets `won`=1 and `win_row`/`win_col`/`win_dir` to the matching window's anchor and direction.
- **No match:** after window 4·N·N−1, go SCAN→DONE with `won`=0.
- **DONE:** lasts exactly one cycle with `done`=1, then the FSM returns to IDLE. `start` arriving in the DONE cycle is ignored.
- `won`, `bad_id` and `win_*` hold from DONE until the next accepted `start`.
- A longer run (more than K cells) reports its first window in scan order.

## Timing
- Let cycle c be the cycle in which `start` is accepted.
  - Window i is evaluated in cycle c+1+i.
  - `done` is high in cycle c+2+i for a hit at index i.
- Worst case (no win) is `done` at c+1+4·N·N; for N=5 that is c+101.
- With an invalid ID, `done` is high at cycle c+1.
- `rst` asserted mid-scan: IDLE and all outputs 0 at the next edge, and no `done` is produced.
- `rst` has priority over `start` in the same cycle.
- The per-window compare is combinational on the registered snapshot. The critical path is a K-way 2-bit compare plus bounds check, with no multi-cycle paths.

## Structure
- Package `win_pkg`:
  - Cell codes `CELL_EMPTY`, `CELL_P1`, `CELL_P2`.
  - Direction enum `dir_e` (`DIR_E`, `DIR_S`, `DIR_SE`, `DIR_SW`).
  - State enum `scan_state_e`.
- Sub-module `win_window_match`: purely combinational, taking (board snapshot, r, c, dir, player) and returning `match`. It is parametrised by N and K.
- Top level holds the FSM, the snapshot registers, the r/c/dir counters and the output registers.

## Test plan
All scenarios use N=5, K=4.
- **Empty board, player 1:** `done` at c+101, `won`=0, `bad_id`=0, and `busy` high from c+1 to c+101.
- **P1 at (2,1)…(2,4), player 1:** `won`=1, `win_row`=2, `win_col`=1, `win_dir`=E, `done` at c+46 (i=44).
- **P2 at (0,4),(1,3),(2,2),(3,1):**
  - With player 2: `won`=1, anchor (0,4), `win_dir`=SW, `done` at c+21.
  - Same board with player 1: `won`=0 at c+101.
- **P1 at (0,3),(0,4),(1,0),(1,1), player 1 (row wrap):** `won`=0. A separate run with `player_id`=3 gives `done` at c+1 with `bad_id`=1 and `won`=0.
- **Change `board` and pulse `start` during a scan:** the result still reflects the snapshot and the extra `start` is ignored.
- **`rst`=1 at c+10:** `busy`=0 next cycle and no `done` pulse. A fresh `start` then completes normally.
